multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle RV32I core.
- Sequences the single shared ALU across fetch, decode, execute, memory and writeback steps.
- Drives the ALU operand muxes, alu_op, and all architectural write enables.
- Waits on a simple memory-ready handshake; sits between the instruction register and the datapath.

Parameters:
- ALU_OP_W, 4, width of alu_op. Bits [3:2] select the class: 00 arithmetic, 01 logic, 10 shift. Bits [1:0] select the sub-op.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- alu_zero  in  1  ALU zero flag
- mem_rdy  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register and old_pc load enable
- adr_src  out  1  memory address select: 0 PC, 1 alu_out
- mem_write  out  1  store strobe
- reg_write  out  1  register file write enable
- result_src  out  2  result bus select: 00 alu_out, 01 mem data, 10 alu_result
- alu_src_a  out  2  ALU operand A select: 00 PC, 01 old_pc, 10 rs1, 11 zero
- alu_src_b  out  2  ALU operand B select: 00 rs2, 01 imm, 10 constant 4
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
- alu_op  out  4  ALU operation
- illegal  out  1  illegal-instruction flag

Behaviour:
- alu_op encoding:
  - ADD 0000, SUB 0001, SLT 0010, SLTU 0011
  - AND 0100, OR 0101, XOR 0110
  - SLL 1000, SRL 1001, SRA 1011
- Reset:
  - While rstn is low, the state is FETCH.
  - pc_write, ir_write, mem_write and reg_write are forced to 0.
  - illegal = 0. All other outputs take their FETCH values.
- Outputs in states not listed below: all enables 0, selects 0, alu_op ADD.
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, ADD, result_src 10.
  - ir_write = pc_write = mem_rdy.
  - Stays in FETCH while mem_rdy = 0; goes to DECODE when mem_rdy = 1.
- DECODE: computes old_pc + imm into alu_out using alu_src_a 01, alu_src_b 01, ADD.
  - imm_src is J when opcode = JAL, otherwise B.
  - Next state by opcode:
    - 0000011 (load) and 0100011 (store) → MEMADR
    - 0110011 → EXEC_R; 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL; 1100111 → JALR
    - 0110111 → LUI; 0010111 → AUIPC
    - any other opcode → ILLEGAL
- MEMADR: rs1 + imm, with imm_src S for stores and I for loads. Goes to MEMREAD (load) or MEMWRITE (store).
- MEMREAD: adr_src 1. Holds until mem_rdy, then goes to MEMWB.
- MEMWB: result_src 01, reg_write 1, then FETCH.
- MEMWRITE: adr_src 1, mem_write 1. Holds until mem_rdy, then FETCH.
- EXEC_R: rs1 op rs2, then ALUWB. alu_op from funct3:
  - 000: ADD, or SUB when funct7b5 = 1
  - 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND
  - 001 SLL; 101 SRL, or SRA when funct7b5 = 1
- EXEC_I: rs1 op imm(I), then ALUWB.
  - Same alu_op mapping as EXEC_R, except funct7b5 is ignored unless funct3 = 101.
- LUI: zero + imm(U), then ALUWB.
- AUIPC: old_pc + imm(U), then ALUWB.
- ALUWB: result_src 00, reg_write 1, then FETCH.
- BRANCH: compares rs1 with rs2, result_src 00, then FETCH.
  - pc_write = taken, which loads the DECODE-computed target.
  - beq/bne: SUB; taken = alu_zero / !alu_zero.
  - blt/bge: SLT; taken = !alu_zero / alu_zero.
  - bltu/bgeu: SLTU; taken = !alu_zero / alu_zero.
  - funct3 010 or 011 → ILLEGAL.
- JAL: pc_write 1, result_src 00 (target), old_pc + 4 computed, then ALUWB.
- JALR: rs1 + imm(I) into alu_out, then JALR_LINK.
- JALR_LINK: same outputs as JAL, then ALUWB. The datapath clears target bit 0.
- ILLEGAL: behaviour set by the optional feature below.
- Reset mid-operation aborts immediately to FETCH; no partial write is issued.
- Latencies with mem_rdy held at 1:
  - 4 cycles: ALU ops, LUI, AUIPC, JAL, stores
  - 5 cycles: loads, JALR
  - 3 cycles: branches

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - ILLEGAL is absorbing until reset; illegal = 1 there.
  - All enables stay 0 while in ILLEGAL.
- ILLEGAL_TRAP_EN undefined:
  - ILLEGAL lasts one cycle with illegal = 1, then returns to FETCH.
  - The instruction executes as a NOP.

Decomposition:
- riscv_pkg holds:
  - opcode constants
  - alu_op encodings
  - the src, result and imm select codes
  - the state enum
- One sub-module, alu_decoder: maps an instruction-class code, funct3 and funct7b5 to alu_op and a branch-invert bit.

Test Plan:
- Reset: rstn low mid-MEMWRITE → mem_write = 0 immediately; state FETCH after release.
- add x3,x1,x2 (funct7b5 = 0) with mem_rdy = 1 → FETCH, DECODE, EXEC_R (alu_op 0000), ALUWB with reg_write = 1; back in FETCH on cycle 5.
- lw with mem_rdy held low 3 cycles in MEMREAD → state holds, adr_src = 1; MEMWB after mem_rdy, result_src = 01.
- bne with alu_zero = 0 → pc_write = 1 in BRANCH, alu_op 0001. Same with alu_zero = 1 → pc_write = 0.
- srai (funct3 101, funct7b5 = 1) → alu_op 1011. addi with funct7b5 = 1 → alu_op 0000.
- opcode 1111111 → illegal = 1. Trap build: stuck with all enables 0. Non-trap build: FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, ALU
// operation codes, datapath select codes and the controller state set.
package riscv_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Bits [3:2] give the class (arith / logic / shift), bits [1:0] the sub-op.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT    = 2'b00,
    RES_MEM_DATA   = 2'b01,
    RES_ALU_RESULT = 2'b10
  } result_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_e;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BRANCH
  } alu_cls_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_AUIPC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_ILLEGAL
  } state_e;

  // funct3 010 and 011 have no branch meaning in RV32I.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps an instruction class plus funct3/funct7b5 to an ALU operation and,
// for branches, whether the zero flag must be inverted to get "taken".
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_cls_e              cls,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  br_inv
);

  always_comb begin
    alu_op = ALU_ADD;
    br_inv = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000: alu_op = (cls == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_ADD;
        endcase
        // bne, blt, bltu are taken on a non-zero ALU result.
        br_inv = funct3[0] ^ funct3[2];
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core. Define ILLEGAL_TRAP_EN to
// make the ILLEGAL state absorbing until reset; otherwise it is a one-cycle NOP.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                alu_zero,
  input  logic                mem_rdy,
  output logic                pc_write,
  output logic                ir_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  state_e   state_q, state_d;
  alu_cls_e alu_cls;
  logic     br_inv;

  alu_decoder u_alu_decoder (
    .cls      (alu_cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (alu_op),
    .br_inv   (br_inv)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = branch_f3_legal(funct3) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC:
                  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_LINK;
      S_JALR_LINK: state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`else
      S_ILLEGAL:  state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode from the current state only, except the FETCH load strobes
  // (which follow mem_rdy) and the branch PC load (which follows alu_zero).
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALU_OUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    imm_src    = IMM_I;
    illegal    = 1'b0;
    alu_cls    = CLS_ADD;
    case (state_q)
      S_FETCH: begin
        // rstn gating keeps the load strobes quiet while reset is held.
        ir_write   = mem_rdy & rstn;
        pc_write   = mem_rdy & rstn;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEM_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_cls   = CLS_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_cls   = CLS_I;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
      end
      S_ALUWB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_cls   = CLS_BRANCH;
        pc_write  = alu_zero ^ br_inv;
      end
      S_JAL, S_JALR_LINK: begin
        // alu_out still holds the jump target; compute the link value old_pc + 4.
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs derived from
// instruction-level rules, checked every cycle, plus literal pins.
module tb_multicycle_ctrl;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_zero;
  logic       mem_rdy;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_op;
  outs_t      dut_o;

  int n_chk  = 0;
  int n_pass = 0;

  outs_t exp_q[$];
  string nm_q[$];

  // R-type funct3 -> op, with funct7b5 = 0
  logic [3:0] r_tab [8] = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h6, 4'h9, 4'h5, 4'h4};

  multicycle_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_zero   (alu_zero),
    .mem_rdy    (mem_rdy),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  assign dut_o = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_op, illegal};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h required %05h", nm, got, exp);
  endtask

  // Single compare process: one expected record per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      chk(n, 32'(dut_o), 32'(e));
    end
  end

  function automatic outs_t o_alu(input logic [1:0] a, input logic [1:0] b,
                                  input logic [2:0] imm, input logic [3:0] op);
    outs_t o;
    o = '0;
    o.alu_src_a = a;
    o.alu_src_b = b;
    o.imm_src   = imm;
    o.alu_op    = op;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic rdy);
    outs_t o;
    o = o_alu(2'b00, 2'b10, 3'b000, 4'h0);
    o.pc_write   = rdy;
    o.ir_write   = rdy;
    o.result_src = 2'b10;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] rs);
    outs_t o;
    o = '0;
    o.reg_write  = 1'b1;
    o.result_src = rs;
    return o;
  endfunction

  function automatic outs_t o_jump();
    outs_t o;
    o = o_alu(2'b01, 2'b10, 3'b000, 4'h0);
    o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic logic [3:0] arith_op(input logic is_r, input logic [2:0] f3, input logic f7);
    logic [3:0] op;
    op = r_tab[f3];
    if (f3 == 3'b000 && f7 && is_r) op = 4'h1;
    if (f3 == 3'b101 && f7) op = 4'hB;
    return op;
  endfunction

  // Push one cycle's expectation, optionally pin alu_op / pc_write to literals.
  task automatic step(input string nm, input outs_t e, input int pin_op = -1, input int pin_pcw = -1);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    if (pin_op >= 0)  chk({nm, "_alu_op_pin"}, 32'(alu_op), 32'(pin_op));
    if (pin_pcw >= 0) chk({nm, "_pc_write_pin"}, 32'(pc_write), 32'(pin_pcw));
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset(input string nm);
    rstn    = 1'b0;
    mem_rdy = 1'b1;
    #1;
    chk({nm, "_async_mem_write"}, 32'(mem_write), 32'd0);
    chk({nm, "_async_outs"}, 32'(dut_o), 32'(o_fetch(1'b0)));
    @(posedge clk);
    #1;
    chk({nm, "_held_outs"}, 32'(dut_o), 32'(o_fetch(1'b0)));
    rstn = 1'b1;
  endtask

  task automatic illegal_seq(input string nm);
    outs_t o;
    o = '0;
    o.illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) step({nm, "_trap"}, o);
    do_reset({nm, "_trap_rst"});
`else
    step({nm, "_illegal"}, o);
`endif
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input int fw, input int mw,
                     input int pin_op = -1, input int pin_pcw = -1, input bit abort = 1'b0);
    outs_t o;
    logic  taken;
    opcode = op; funct3 = f3; funct7b5 = f7; alu_zero = z;
    for (int i = 0; i < fw; i++) begin
      mem_rdy = 1'b0;
      step({nm, "_fetch_wait"}, o_fetch(1'b0));
    end
    mem_rdy = 1'b1;
    step({nm, "_fetch"}, o_fetch(1'b1));
    step({nm, "_decode"}, o_alu(2'b01, 2'b01, (op == T_JAL) ? 3'b100 : 3'b010, 4'h0));
    case (op)
      T_LOAD, T_STORE: begin
        step({nm, "_memadr"}, o_alu(2'b10, 2'b01, (op == T_STORE) ? 3'b001 : 3'b000, 4'h0));
        o = '0;
        o.adr_src   = 1'b1;
        o.mem_write = (op == T_STORE);
        for (int i = 0; i < mw; i++) begin
          mem_rdy = 1'b0;
          step({nm, "_mem_wait"}, o);
        end
        if (abort) begin
          do_reset({nm, "_abort"});
          return;
        end
        mem_rdy = 1'b1;
        step({nm, "_mem_done"}, o);
        if (op == T_LOAD) step({nm, "_memwb"}, o_wb(2'b01));
      end
      T_R, T_I: begin
        step({nm, "_exec"}, o_alu(2'b10, (op == T_R) ? 2'b00 : 2'b01, 3'b000,
                                   arith_op(op == T_R, f3, f7)), pin_op);
        step({nm, "_aluwb"}, o_wb(2'b00));
      end
      T_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          illegal_seq(nm);
        end else begin
          case (f3)
            3'b000:          taken = z;
            3'b001:          taken = !z;
            3'b100, 3'b110:  taken = !z;   // less-than result of 1 is non-zero
            default:         taken = z;
          endcase
          o = o_alu(2'b10, 2'b00, 3'b000,
                    (f3[2] == 1'b0) ? 4'h1 : (f3[1] ? 4'h3 : 4'h2));
          o.pc_write = taken;
          step({nm, "_branch"}, o, pin_op, pin_pcw);
        end
      end
      T_JAL: begin
        step({nm, "_jal"}, o_jump());
        step({nm, "_aluwb"}, o_wb(2'b00));
      end
      T_JALR: begin
        step({nm, "_jalr"}, o_alu(2'b10, 2'b01, 3'b000, 4'h0));
        step({nm, "_jalr_link"}, o_jump());
        step({nm, "_aluwb"}, o_wb(2'b00));
      end
      T_LUI: begin
        step({nm, "_lui"}, o_alu(2'b11, 2'b01, 3'b011, 4'h0));
        step({nm, "_aluwb"}, o_wb(2'b00));
      end
      T_AUIPC: begin
        step({nm, "_auipc"}, o_alu(2'b01, 2'b01, 3'b011, 4'h0));
        step({nm, "_aluwb"}, o_wb(2'b00));
      end
      default: illegal_seq(nm);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; alu_zero = 1'b0; mem_rdy = 1'b1;
    @(posedge clk);
    #1;
    do_reset("por");

    run("add",     T_R,     3'b000, 1'b0, 1'b0, 0, 0, 4'b0000);
    run("sub",     T_R,     3'b000, 1'b1, 1'b0, 1, 0, 4'b0001);
    run("sra",     T_R,     3'b101, 1'b1, 1'b0, 0, 0, 4'b1011);
    run("sltu",    T_R,     3'b011, 1'b0, 1'b0, 0, 0, 4'b0011);
    run("or",      T_R,     3'b110, 1'b0, 1'b0, 0, 0, 4'b0101);
    run("lw",      T_LOAD,  3'b010, 1'b0, 1'b0, 2, 3);
    run("sw",      T_STORE, 3'b010, 1'b0, 1'b0, 0, 1);
    run("beq_t",   T_BR,    3'b000, 1'b0, 1'b1, 0, 0, 4'b0001, 1);
    run("bne_t",   T_BR,    3'b001, 1'b0, 1'b0, 0, 0, 4'b0001, 1);
    run("bne_nt",  T_BR,    3'b001, 1'b0, 1'b1, 0, 0, 4'b0001, 0);
    run("blt_t",   T_BR,    3'b100, 1'b0, 1'b0, 0, 0, 4'b0010, 1);
    run("bgeu_nt", T_BR,    3'b111, 1'b0, 1'b0, 0, 0, 4'b0011, 0);
    run("srai",    T_I,     3'b101, 1'b1, 1'b0, 0, 0, 4'b1011);
    run("addi_f7", T_I,     3'b000, 1'b1, 1'b0, 0, 0, 4'b0000);
    run("xori",    T_I,     3'b100, 1'b0, 1'b0, 0, 0, 4'b0110);
    run("slli",    T_I,     3'b001, 1'b0, 1'b0, 0, 0, 4'b1000);
    run("lui",     T_LUI,   3'b000, 1'b0, 1'b0, 0, 0);
    run("auipc",   T_AUIPC, 3'b000, 1'b0, 1'b0, 0, 0);
    run("jal",     T_JAL,   3'b000, 1'b0, 1'b0, 0, 0);
    run("jalr",    T_JALR,  3'b000, 1'b0, 1'b0, 0, 0);
    run("ill_op",  7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    run("ill_br",  T_BR,    3'b010, 1'b0, 1'b0, 0, 0);
    run("sw_abort", T_STORE, 3'b010, 1'b0, 1'b0, 0, 2, -1, -1, 1'b1);
    run("and",     T_R,     3'b111, 1'b0, 1'b0, 0, 0, 4'b0100);

    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
